// File: rtl/lock_pkg.sv
// Shared definitions for the pass_lock door controller: state encoding,
// door-select constants and a small elaboration-time helper.
package lock_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    WAIT_PASS = 3'd1,
    OPEN      = 3'd2,
    DENY      = 3'd3,
    LOCKOUT   = 3'd4
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pass_lock_if.sv
// Keypad/switch front end to door actuator bundle. The front end is the
// master (drives the request side); the lock controller is the slave.
interface pass_lock_if #(
  parameter int PASS_W    = 4,
  parameter int MAX_TRIES = 3
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  logic                         request;
  logic                         dir;
  logic                         confirm;
  logic                         prog;
  logic [PASS_W-1:0]            pass_data;
  logic                         en_left;
  logic                         en_right;
  logic                         alarm;
  logic                         err;
  logic [TRY_W-1:0]             dout;
  logic [lock_pkg::STATE_W-1:0] state;

  modport master (
    output request, dir, confirm, prog, pass_data,
    input  en_left, en_right, alarm, err, dout, state
  );

  modport slave (
    input  request, dir, confirm, prog, pass_data,
    output en_left, en_right, alarm, err, dout, state
  );

endinterface

// File: rtl/lock_timer.sv
// Saturating down-counter shared by the door-open window and the alarm
// lockout. A load strobe presets the count; zero flags the final cycle.
module lock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load wins over counting; otherwise count down and hold at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/pass_lock.sv
// Password door lock: checks an entered code, opens the selected door for a
// fixed window, counts consecutive failures into a timed alarm lockout, and
// allows the password to be rewritten while a door is open.
module pass_lock
  import lock_pkg::*;
#(
  parameter int              PASS_W    = 4,
  parameter logic [PASS_W-1:0] PASSWORD = 4'b1010,
  parameter int              MAX_TRIES = 3,
  parameter int              OPEN_CYC  = 8,
  parameter int              LOCK_CYC  = 16
) (
  input logic        clk,
  input logic        rst,
  pass_lock_if.slave bus
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W = max_int(1, $clog2(max_int(OPEN_CYC, LOCK_CYC)));

  state_t            state_q, state_d;
  logic [TRY_W-1:0]  fails_q, fails_d;
  logic              dir_q, dir_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_zero;

  lock_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Next-state, failure count, door latch, password update and timer preset.
  always_comb begin
    state_d  = state_q;
    fails_d  = fails_q;
    dir_d    = dir_q;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE: begin
        if (bus.request) begin
          dir_d   = bus.dir;
          state_d = WAIT_PASS;
        end
      end
      WAIT_PASS: begin
        if (!bus.request) begin
          state_d = IDLE;
        end else if (bus.confirm) begin
          if (bus.pass_data == pass_q) begin
            state_d  = OPEN;
            fails_d  = '0;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(OPEN_CYC - 1);
          end else begin
            fails_d = fails_q + TRY_W'(1);
            if (fails_q == TRY_W'(MAX_TRIES - 1)) begin
              state_d  = LOCKOUT;
              tmr_load = 1'b1;
              tmr_val  = TMR_W'(LOCK_CYC - 1);
            end else begin
              state_d = DENY;
            end
          end
        end
      end
      OPEN: begin
        if (bus.confirm && bus.prog) begin
          pass_d = bus.pass_data;
        end
        if (tmr_zero) begin
          state_d = IDLE;
        end
      end
      DENY: begin
        state_d = bus.request ? WAIT_PASS : IDLE;
      end
      LOCKOUT: begin
        if (tmr_zero) begin
          state_d = IDLE;
          fails_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller registers; reset restores the factory password.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      fails_q <= '0;
      dir_q   <= DIR_LEFT;
      pass_q  <= PASSWORD;
    end else begin
      state_q <= state_d;
      fails_q <= fails_d;
      dir_q   <= dir_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.en_left  = (state_q == OPEN) && (dir_q == DIR_LEFT);
  assign bus.en_right = (state_q == OPEN) && (dir_q == DIR_RIGHT);
  assign bus.alarm    = (state_q == LOCKOUT);
  assign bus.err      = (state_q == DENY);
  assign bus.dout     = TRY_W'(MAX_TRIES) - fails_q;
  assign bus.state    = state_q;

endmodule
